aes_decrypt_iter: RTL and testbench



---
 rtl/aes_decrypt_iter.sv | 191 +++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: forward key schedule up to k10, then one
// decryption round per clock while the key schedule is stepped backwards.
module aes_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] data,
  output logic         busy,
  output logic         done,
  output logic [127:0] r_out
);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_t;

  state_t       r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_key, r_ct, r_state;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte n = row + 4*col lives at bits 8*(15-n) +: 8.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+4-r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++)
      o[8*n +: 8] = inv_sbox(s[8*n +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[8*(14-4*c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[8*(13-4*c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[8*(12-4*c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [31:0]  w_inv_w1, w_inv_w2, w_inv_w3, w_sub_in, w_t;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [7:0]   w_rcon;
  logic [127:0] w_key_fwd, w_key_prev, w_add, w_round;

  // One SubWord unit is shared: forward step uses RotWord(w3), inverse uses RotWord(w3').
  always_comb begin
    w_inv_w3 = r_key[31:0]  ^ r_key[63:32];
    w_inv_w2 = r_key[63:32] ^ r_key[95:64];
    w_inv_w1 = r_key[95:64] ^ r_key[127:96];
    if (r_fsm == DEC) begin
      w_sub_in = {w_inv_w3[23:0], w_inv_w3[31:24]};
      w_rcon   = rcon(r_cnt + 4'd1);
    end else begin
      w_sub_in = {r_key[23:0], r_key[31:24]};
      w_rcon   = rcon(r_cnt);
    end
    w_t        = subword(w_sub_in) ^ {w_rcon, 24'h0};
    w_f0       = r_key[127:96] ^ w_t;
    w_f1       = r_key[95:64]  ^ w_f0;
    w_f2       = r_key[63:32]  ^ w_f1;
    w_f3       = r_key[31:0]   ^ w_f2;
    w_key_fwd  = {w_f0, w_f1, w_f2, w_f3};
    w_key_prev = {r_key[127:96] ^ w_t, w_inv_w1, w_inv_w2, w_inv_w3};
    w_add      = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_key_prev;
    w_round    = (r_cnt == '0) ? w_add : inv_mix_columns(w_add);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_ct    <= '0;
      r_state <= '0;
      r_out   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (start) begin
            r_key <= key;
            r_ct  <= data;
            r_cnt <= 4'd1;
            busy  <= 1'b1;
            r_fsm <= KEYEXP;
          end
        end
        KEYEXP: begin
          r_key <= w_key_fwd;
          if (r_cnt == 4'(NR)) begin
            r_state <= r_ct ^ w_key_fwd;
            r_cnt   <= 4'(NR - 1);
            r_fsm   <= DEC;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DEC: begin
          r_key   <= w_key_prev;
          r_state <= w_round;
          if (r_cnt == '0) begin
            r_out <= w_round;
            done  <= 1'b1;
            busy  <= 1'b0;
            r_fsm <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter against a table-driven AES-128
// InvCipher model built from GF(2^8) arithmetic at time zero.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] data = '0;
  logic         busy, done;
  logic [127:0] r_out;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  aes_decrypt_iter #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key   (key),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .r_out (r_out)
  );

  logic [7:0] m_sbox  [256];
  logic [7:0] m_isbox [256];
  logic [7:0] m_rcon  [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Carry-less product then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (prod[i]) prod = prod ^ (15'h11b << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      m_sbox[x] = s;
    end
    for (int x = 0; x < 256; x++) m_isbox[m_sbox[x]] = 8'(x);
  endtask

  function automatic logic [127:0] m_round_key(input logic [127:0] k, input int round);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*round + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ m_rcon[i/4 - 1];
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*round], w[4*round+1], w[4*round+2], w[4*round+3]};
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] k, input logic [127:0] ct);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    rk = m_round_key(k, 10);
    for (int n = 0; n < 16; n++) st[n] = ct[127-8*n -: 8] ^ rk[127-8*n -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r+4*c] = st[r+4*((c+4-r)%4)];
      rk = m_round_key(k, rnd);
      for (int n = 0; n < 16; n++) st[n] = m_isbox[tmp[n]] ^ rk[127-8*n -: 8];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = m_mul(a0, 8'd14) ^ m_mul(a1, 8'd11) ^ m_mul(a2, 8'd13) ^ m_mul(a3, 8'd9);
          st[4*c+1] = m_mul(a0, 8'd9)  ^ m_mul(a1, 8'd14) ^ m_mul(a2, 8'd11) ^ m_mul(a3, 8'd13);
          st[4*c+2] = m_mul(a0, 8'd13) ^ m_mul(a1, 8'd9)  ^ m_mul(a2, 8'd14) ^ m_mul(a3, 8'd11);
          st[4*c+3] = m_mul(a0, 8'd11) ^ m_mul(a1, 8'd13) ^ m_mul(a2, 8'd9)  ^ m_mul(a3, 8'd14);
        end
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives one block; mode 1 scrambles key/data every cycle, mode 2 pulses start mid-block.
  task automatic run_block(input logic [127:0] k, input logic [127:0] d, input int mode,
                           output logic [127:0] pt, output int busy_cyc, output int done_at,
                           output int ndone, output logic [127:0] k10_seen,
                           output logic [127:0] kfin_seen);
    @(negedge clk);
    key = k; data = d; start = 1'b1;
    pt = '0; busy_cyc = 0; done_at = -1; ndone = 0; k10_seen = '0; kfin_seen = '0;
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
        pt = r_out;
      end
      if (n == 10) k10_seen = dut.r_key;
      if (n == 20) kfin_seen = dut.r_key;
      if (mode == 1) begin key = rand128(); data = rand128(); end
      if (mode == 2 && (n == 5 || n == 15)) begin
        start = 1'b1; key = rand128(); data = rand128();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (r_out !== '0) begin errors++; $display("FAIL reset_rout: got %h want 0", r_out); end
    reset = 1'b0;
  endtask

  task automatic test_c1();
    logic [127:0] pt, k10, kf; int bc, da, nd;
    run_block(C1_KEY, C1_CT, 0, pt, bc, da, nd, k10, kf);
    checks++; if (da != 20) begin errors++; $display("FAIL c1_done_at: got %0d want 20", da); end
    checks++; if (nd != 1) begin errors++; $display("FAIL c1_ndone: got %0d want 1", nd); end
    checks++; if (bc != 20) begin errors++; $display("FAIL c1_busy_cycles: got %0d want 20", bc); end
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL c1_pt: got %h want %h", pt, C1_PT); end
    checks++; if (pt !== m_decrypt(C1_KEY, C1_CT)) begin errors++; $display("FAIL c1_pt_model: got %h want %h", pt, m_decrypt(C1_KEY, C1_CT)); end
    checks++; if (r_out !== C1_PT) begin errors++; $display("FAIL c1_hold: got %h want %h", r_out, C1_PT); end
  endtask

  task automatic test_fips_b();
    logic [127:0] pt, k10, kf; int bc, da, nd;
    run_block(B_KEY, B_CT, 0, pt, bc, da, nd, k10, kf);
    checks++; if (pt !== B_PT) begin errors++; $display("FAIL b_pt: got %h want %h", pt, B_PT); end
    checks++; if (k10 !== B_K10) begin errors++; $display("FAIL b_k10: got %h want %h", k10, B_K10); end
    checks++; if (k10 !== m_round_key(B_KEY, 10)) begin errors++; $display("FAIL b_k10_model: got %h want %h", k10, m_round_key(B_KEY, 10)); end
    checks++; if (kf !== B_KEY) begin errors++; $display("FAIL b_key_final: got %h want %h", kf, B_KEY); end
  endtask

  task automatic test_start_ignored();
    logic [127:0] pt, k10, kf; int bc, da, nd;
    run_block(C1_KEY, C1_CT, 2, pt, bc, da, nd, k10, kf);
    checks++; if (nd != 1) begin errors++; $display("FAIL ign_ndone: got %0d want 1", nd); end
    checks++; if (da != 20) begin errors++; $display("FAIL ign_done_at: got %0d want 20", da); end
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL ign_pt: got %h want %h", pt, C1_PT); end
  endtask

  task automatic test_start_held();
    logic [127:0] bk [3];
    logic [127:0] bd [3];
    int idx;
    for (int i = 0; i < 3; i++) begin bk[i] = rand128(); bd[i] = rand128(); end
    idx = 0;
    @(negedge clk);
    key = bk[0]; data = bd[0]; start = 1'b1;
    for (int n = 0; n < 66; n++) begin
      @(negedge clk);
      if (n == 0)  begin key = bk[1]; data = bd[1]; end
      if (n == 21) begin key = bk[2]; data = bd[2]; end
      if (done) begin
        if (idx < 3) begin
          checks++; if (n != 20 + 21*idx) begin errors++; $display("FAIL held_done_at%0d: got %0d want %0d", idx, n, 20 + 21*idx); end
          checks++; if (r_out !== m_decrypt(bk[idx], bd[idx])) begin errors++; $display("FAIL held_pt%0d: got %h want %h", idx, r_out, m_decrypt(bk[idx], bd[idx])); end
        end
        idx++;
      end
    end
    start = 1'b0;
    checks++; if (idx != 3) begin errors++; $display("FAIL held_ndone: got %0d want 3", idx); end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int b_at; logic held_ok; logic [127:0] b_pt;
    b_at = -1; held_ok = 1'b1; b_pt = '0;
    @(negedge clk);
    key = C1_KEY; data = C1_CT; start = 1'b1;
    for (int n = 0; n < 46; n++) begin
      @(negedge clk);
      if (n == 0 || n == 21) start = 1'b0;
      if (n == 20) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
        checks++; if (r_out !== C1_PT) begin errors++; $display("FAIL b2b_first_pt: got %h want %h", r_out, C1_PT); end
        key = B_KEY; data = B_CT; start = 1'b1;
      end
      if (n >= 21 && n <= 40 && r_out !== C1_PT) held_ok = 1'b0;
      if (n > 20 && done && b_at < 0) begin b_at = n; b_pt = r_out; end
    end
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b want 1", held_ok); end
    checks++; if (b_at != 41) begin errors++; $display("FAIL b2b_second_at: got %0d want 41", b_at); end
    checks++; if (b_pt !== B_PT) begin errors++; $display("FAIL b2b_second_pt: got %h want %h", b_pt, B_PT); end
  endtask

  task automatic test_reset_midop();
    logic [127:0] k, d, pt, k10, kf; int bc, da, nd, stray;
    stray = 0;
    @(negedge clk);
    key = rand128(); data = rand128(); start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 11) reset = 1'b1;
      if (n == 12) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
        checks++; if (r_out !== '0) begin errors++; $display("FAIL rst_mid_rout: got %h want 0", r_out); end
        reset = 1'b0;
      end
      if (n > 12 && done) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_stray_done: got %0d want 0", stray); end
    k = rand128(); d = rand128();
    run_block(k, d, 0, pt, bc, da, nd, k10, kf);
    checks++; if (da != 20) begin errors++; $display("FAIL rst_after_done_at: got %0d want 20", da); end
    checks++; if (pt !== m_decrypt(k, d)) begin errors++; $display("FAIL rst_after_pt: got %h want %h", pt, m_decrypt(k, d)); end
  endtask

  task automatic test_input_stability();
    logic [127:0] k, d, pt, k10, kf; int bc, da, nd;
    for (int i = 0; i < 4; i++) begin
      k = rand128(); d = rand128();
      run_block(k, d, 1, pt, bc, da, nd, k10, kf);
      checks++; if (da != 20) begin errors++; $display("FAIL stab%0d_done_at: got %0d want 20", i, da); end
      checks++; if (pt !== m_decrypt(k, d)) begin errors++; $display("FAIL stab%0d_pt: got %h want %h", i, pt, m_decrypt(k, d)); end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_c1();
    test_fips_b();
    test_start_ignored();
    test_start_held();
    test_back_to_back();
    test_reset_midop();
    test_input_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
